// File: rtl/sobel_edge_stage.sv
// Pixel-stream Sobel edge stage: RGB -> gray, 3x3 window from two line buffers,
// selectable pass/gray/magnitude/binary-edge output. EDGE_OVERLAY_EN: red edge overlay in mode 11.
module sobel_edge_stage #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned DW       = 10
) (
  input  logic          iCLK,
  input  logic          iRST,
  input  logic          iSOF,
  input  logic          iDVAL,
  input  logic [DW-1:0] iRed,
  input  logic [DW-1:0] iGreen,
  input  logic [DW-1:0] iBlue,
  input  logic [1:0]    iMode,
  input  logic [DW-1:0] iThresh,
  output logic [DW-1:0] oRed,
  output logic [DW-1:0] oGreen,
  output logic [DW-1:0] oBlue,
  output logic          oDVAL
);

  localparam int unsigned CW = $clog2(H_ACTIVE);
  localparam int unsigned RW = 11;
  localparam int unsigned GW = DW + 2;
  localparam int unsigned SW = DW + 3;
  localparam int unsigned MW = DW + 4;
  localparam logic [DW-1:0] PIX_MAX = '1;

  typedef enum logic [1:0] {
    MODE_PASS = 2'b00,
    MODE_GRAY = 2'b01,
    MODE_MAG  = 2'b10,
    MODE_EDGE = 2'b11
  } mode_t;

  // ---------------- S1: gray, counters, line buffers ----------------
  logic [CW-1:0] col, col_eff;
  logic [RW-1:0] row, row_eff;
  logic [GW-1:0] gray_sum;
  logic [DW-1:0] gray_in;

  always_comb begin
    col_eff  = iSOF ? '0 : col;
    row_eff  = iSOF ? '0 : row;
    gray_sum = {2'b00, iRed} + {1'b0, iGreen, 1'b0} + {2'b00, iBlue};
    gray_in  = gray_sum[GW-1:2];
  end

  logic [DW-1:0] lb0 [H_ACTIVE];
  logic [DW-1:0] lb1 [H_ACTIVE];
  logic [DW-1:0] lb0_q, lb1_q;

  // Contents are never cleared; rows 0-1 of a frame are masked by window_ok.
  always_ff @(posedge iCLK) begin
    if (iDVAL && !iRST) begin
      lb0_q        <= lb0[col_eff];
      lb1_q        <= lb1[col_eff];
      lb1[col_eff] <= lb0[col_eff];
      lb0[col_eff] <= gray_in;
    end
  end

  logic          v1, ok1;
  logic [DW-1:0] gray1, red1, grn1, blu1;

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      col   <= '0;
      row   <= '0;
      v1    <= 1'b0;
      ok1   <= 1'b0;
      gray1 <= '0;
      red1  <= '0;
      grn1  <= '0;
      blu1  <= '0;
    end else begin
      v1 <= iDVAL;
      if (iDVAL) begin
        gray1 <= gray_in;
        red1  <= iRed;
        grn1  <= iGreen;
        blu1  <= iBlue;
        ok1   <= (row_eff >= RW'(2)) && (col_eff >= CW'(2));
        if (col_eff == CW'(H_ACTIVE - 1)) begin
          col <= '0;
          row <= (row_eff == '1) ? row_eff : row_eff + RW'(1);
        end else begin
          col <= col_eff + CW'(1);
          row <= row_eff;
        end
      end else if (iSOF) begin
        col <= '0;
        row <= '0;
      end
    end
  end

  // ---------------- S2: window shift and gradients ----------------
  logic [DW-1:0] win   [3][3];
  logic [DW-1:0] w_nxt [3][3];
  logic signed [SW-1:0] gx_c, gy_c;

  function automatic logic signed [SW-1:0] ext(input logic [DW-1:0] v);
    return $signed({{(SW-DW){1'b0}}, v});
  endfunction

  // Gradients are taken from the post-shift window so they register with the pixel.
  always_comb begin
    for (int unsigned i = 0; i < 3; i++) begin
      w_nxt[i][0] = win[i][1];
      w_nxt[i][1] = win[i][2];
    end
    w_nxt[0][2] = lb1_q;
    w_nxt[1][2] = lb0_q;
    w_nxt[2][2] = gray1;
    gx_c = (ext(w_nxt[0][2]) + (ext(w_nxt[1][2]) <<< 1) + ext(w_nxt[2][2]))
         - (ext(w_nxt[0][0]) + (ext(w_nxt[1][0]) <<< 1) + ext(w_nxt[2][0]));
    gy_c = (ext(w_nxt[2][0]) + (ext(w_nxt[2][1]) <<< 1) + ext(w_nxt[2][2]))
         - (ext(w_nxt[0][0]) + (ext(w_nxt[0][1]) <<< 1) + ext(w_nxt[0][2]));
  end

  always_ff @(posedge iCLK) begin
    if (v1) win <= w_nxt;
  end

  logic                 v2, ok2;
  logic signed [SW-1:0] gx2, gy2;
  logic [DW-1:0]        centre2, red2, grn2, blu2;

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      v2      <= 1'b0;
      ok2     <= 1'b0;
      gx2     <= '0;
      gy2     <= '0;
      centre2 <= '0;
      red2    <= '0;
      grn2    <= '0;
      blu2    <= '0;
    end else begin
      v2 <= v1;
      if (v1) begin
        ok2     <= ok1;
        gx2     <= gx_c;
        gy2     <= gy_c;
        centre2 <= w_nxt[1][1];
        red2    <= red1;
        grn2    <= grn1;
        blu2    <= blu1;
      end
    end
  end

  // ---------------- S3: magnitude, threshold, mode mux ----------------
  logic [SW-1:0] ax, ay;
  logic [MW-1:0] mag_sum;
  logic [DW-1:0] mag, r_nx, g_nx, b_nx;
  logic          is_edge;

  always_comb begin
    ax      = gx2[SW-1] ? $unsigned(-gx2) : $unsigned(gx2);
    ay      = gy2[SW-1] ? $unsigned(-gy2) : $unsigned(gy2);
    mag_sum = {1'b0, ax} + {1'b0, ay};
    mag     = (mag_sum > MW'(PIX_MAX)) ? PIX_MAX : mag_sum[DW-1:0];
    is_edge = ok2 && (mag >= iThresh);
    r_nx    = '0;
    g_nx    = '0;
    b_nx    = '0;
    case (mode_t'(iMode))
      MODE_PASS: begin
        r_nx = red2;
        g_nx = grn2;
        b_nx = blu2;
      end
      MODE_GRAY: begin
        r_nx = centre2;
        g_nx = centre2;
        b_nx = centre2;
      end
      MODE_MAG: begin
        if (ok2) begin
          r_nx = mag;
          g_nx = mag;
          b_nx = mag;
        end
      end
      MODE_EDGE: begin
`ifdef EDGE_OVERLAY_EN
        if (is_edge) begin
          r_nx = PIX_MAX;
        end else begin
          r_nx = red2;
          g_nx = grn2;
          b_nx = blu2;
        end
`else
        if (is_edge) begin
          r_nx = PIX_MAX;
          g_nx = PIX_MAX;
          b_nx = PIX_MAX;
        end
`endif
      end
      default: ;
    endcase
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      oDVAL  <= 1'b0;
      oRed   <= '0;
      oGreen <= '0;
      oBlue  <= '0;
    end else begin
      oDVAL  <= v2;
      oRed   <= v2 ? r_nx : '0;
      oGreen <= v2 ? g_nx : '0;
      oBlue  <= v2 ? b_nx : '0;
    end
  end

endmodule
